// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scan-out
// prefetch and a pixel-writer port, and double-buffers the framebuffer by
// swapping the scanned-out bank during vertical blanking.
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int PIX_BITS = 4,
  parameter int PPW      = 4,
  parameter int FA_BITS  = 17
) (
  input  logic                      PIXEL_CLK,
  input  logic                      RESET_N,
  input  logic [12:0]               locX,
  input  logic [12:0]               locY,
  input  logic                      in_image,
  input  logic                      wr_req,
  input  logic [FA_BITS-1:0]        wr_addr,
  input  logic [PIX_BITS*PPW-1:0]   wr_data,
  output logic                      wr_ack,
  input  logic                      swap_req,
  output logic                      swap_done,
  output logic                      front_bank,
  output logic [FA_BITS:0]          mem_addr,
  output logic                      mem_re,
  output logic                      mem_we,
  output logic [PIX_BITS*PPW-1:0]   mem_wdata,
  input  logic [PIX_BITS*PPW-1:0]   mem_rdata,
  output logic [PIX_BITS-1:0]       pix_out,
  output logic                      pix_valid
);

  localparam int WORD_BITS = PIX_BITS * PPW;
  localparam int G         = H_ACTIVE / PPW;
  localparam int SEL_BITS  = $clog2(PPW);

  typedef enum logic {
    WR_IDLE,
    WR_WRITE
  } wr_state_t;

  wr_state_t                wr_state;

  logic [31:0]              x32;
  logic [31:0]              y32;
  logic [31:0]              grp32;
  logic [SEL_BITS-1:0]      sel;
  logic                     fetch_hit;
  logic [FA_BITS-1:0]       fetch_addr;
  logic                     arm_pos;
  logic                     swap_pt;
  logic                     vid_en;
  logic                     vid_slot;
  logic                     rd_valid;
  logic [WORD_BITS-1:0]     next_word;
  logic [WORD_BITS-1:0]     cur_word;
  logic [WORD_BITS-1:0]     pix_word;
  logic [WORD_BITS-1:0]     pix_shift;
  logic [PIX_BITS-1:0]      pix_sel;
  logic                     swap_pending;

  assign x32     = {19'd0, locX};
  assign y32     = {19'd0, locY};
  assign grp32   = x32 >> SEL_BITS;
  assign sel     = locX[SEL_BITS-1:0];

  // Row-0 prefetch position, also the point where video fetching is (re)armed
  assign arm_pos = (x32 == H_TOTAL - PPW) && (y32 == V_TOTAL - 1);
  // First cycle of vertical blanking: the only cycle a bank swap may apply
  assign swap_pt = (x32 == '0) && (y32 == V_ACTIVE);

  // Fixed prefetch schedule: next group of this row, or group 0 of the next row
  always_comb begin
    fetch_hit  = 1'b0;
    fetch_addr = '0;
    if ((sel == '0) && (grp32 <= G - 2) && (y32 < V_ACTIVE)) begin
      fetch_hit  = 1'b1;
      fetch_addr = FA_BITS'(y32 * G + grp32 + 1);
    end else if (x32 == H_TOTAL - PPW) begin
      if (y32 + 1 < V_ACTIVE) begin
        fetch_hit  = 1'b1;
        fetch_addr = FA_BITS'((y32 + 1) * G);
      end else if (y32 == V_TOTAL - 1) begin
        fetch_hit  = 1'b1;
        fetch_addr = '0;
      end
    end
  end

  // After reset, fetching stays off until the row-0 prefetch so scan-out
  // always restarts on a frame boundary.
  assign vid_slot = fetch_hit && (vid_en || arm_pos);

  // Pixel select; the word being loaded this cycle is forwarded directly
  always_comb begin
    pix_word  = (sel == '0) ? next_word : cur_word;
    pix_shift = pix_word >> ({{(32-SEL_BITS){1'b0}}, sel} * PIX_BITS);
    pix_sel   = pix_shift[PIX_BITS-1:0];
  end

  // Memory port scheduler and writer FSM: video reads win, writes take free cycles
  always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_state  <= WR_IDLE;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
    end else begin
      mem_re <= vid_slot;
      mem_we <= 1'b0;
      wr_ack <= 1'b0;
      if (vid_slot) begin
        mem_addr <= {front_bank, fetch_addr};
      end
      case (wr_state)
        WR_IDLE: begin
          if (wr_req && !vid_slot) begin
            wr_state  <= WR_WRITE;
            mem_we    <= 1'b1;
            wr_ack    <= 1'b1;
            mem_addr  <= {~front_bank, wr_addr};
            mem_wdata <= wr_data;
          end
        end
        WR_WRITE: wr_state <= WR_IDLE;
        default:  wr_state <= WR_IDLE;
      endcase
    end
  end

  // Bank swap: latch requests, apply at the start of vblank
  always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      if (swap_pt && swap_pending) begin
        front_bank   <= ~front_bank;
        swap_done    <= 1'b1;
        swap_pending <= swap_req;
      end else begin
        swap_pending <= swap_pending | swap_req;
      end
    end
  end

  // Video datapath: capture read data, load the display word, emit pixels
  always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vid_en    <= 1'b0;
      rd_valid  <= 1'b0;
      next_word <= '0;
      cur_word  <= '0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else begin
      if (arm_pos) begin
        vid_en <= 1'b1;
      end
      rd_valid <= mem_re;
      if (rd_valid) begin
        next_word <= mem_rdata;
      end
      if ((sel == '0) && in_image) begin
        cur_word <= next_word;
      end
      pix_valid <= in_image;
      pix_out   <= in_image ? pix_sel : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter on a reduced raster, with a bench-side RAM and
// a frame-level reference model of scan-out, write arbitration and swaps.
module tb_vga_fb_arbiter;

  localparam int H_ACTIVE  = 16;
  localparam int H_TOTAL   = 24;
  localparam int V_ACTIVE  = 6;
  localparam int V_TOTAL   = 9;
  localparam int PIX_BITS  = 4;
  localparam int PPW       = 4;
  localparam int FA_BITS   = 5;
  localparam int WORD_BITS = PIX_BITS * PPW;
  localparam int G         = H_ACTIVE / PPW;
  localparam int AW        = FA_BITS + 1;
  localparam int MEM_WORDS = 2 ** AW;
  localparam int FRAME     = H_TOTAL * V_TOTAL;

  logic                   PIXEL_CLK = 1'b0;
  logic                   RESET_N;
  logic [12:0]            locX, locY;
  logic                   in_image;
  logic                   wr_req;
  logic [FA_BITS-1:0]     wr_addr;
  logic [WORD_BITS-1:0]   wr_data;
  logic                   wr_ack;
  logic                   swap_req;
  logic                   swap_done;
  logic                   front_bank;
  logic [FA_BITS:0]       mem_addr;
  logic                   mem_re, mem_we;
  logic [WORD_BITS-1:0]   mem_wdata, mem_rdata;
  logic [PIX_BITS-1:0]    pix_out;
  logic                   pix_valid;

  always #5 PIXEL_CLK = ~PIXEL_CLK;

  vga_fb_arbiter #(
    .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
    .PIX_BITS(PIX_BITS), .PPW(PPW), .FA_BITS(FA_BITS)
  ) dut (
    .PIXEL_CLK(PIXEL_CLK), .RESET_N(RESET_N), .locX(locX), .locY(locY),
    .in_image(in_image), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .swap_req(swap_req), .swap_done(swap_done),
    .front_bank(front_bank), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pix_out(pix_out),
    .pix_valid(pix_valid)
  );

  logic [WORD_BITS-1:0] ram [MEM_WORDS];

  int checks = 0;
  int errors = 0;
  int bx, by, px, py, w_addr, wmode;
  int e_re, e_raddr, e_we, e_waddr, e_wdata, e_ack, e_sd, e_pix, e_pv, e_fb;
  int fb_m, pend_m;
  bit prev_grant, armed_m, pix_chk, p_chk, prst, swap_rand, dir_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void fetch_rule(input int x, input int y, output bit hit, output int a);
    hit = 1'b0;
    a   = 0;
    if (x % PPW == 0 && x / PPW <= G - 2 && y < V_ACTIVE) begin
      hit = 1'b1; a = y * G + x / PPW + 1;
    end else if (x == H_TOTAL - PPW) begin
      if (y + 1 < V_ACTIVE) begin hit = 1'b1; a = (y + 1) * G; end
      else if (y == V_TOTAL - 1) begin hit = 1'b1; a = 0; end
    end
  endfunction

  task automatic drive_raster();
    locX     = 13'(bx);
    locY     = 13'(by);
    in_image = (bx < H_ACTIVE) && (by < V_ACTIVE);
  endtask

  task automatic new_req();
    w_addr  = int'($urandom_range(V_ACTIVE * G - 1, 0));
    wr_addr = FA_BITS'(w_addr);
    wr_data = WORD_BITS'($urandom);
    wr_req  = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_re"},    32'(mem_re),     0);
    chk({tag, "_we"},    32'(mem_we),     0);
    chk({tag, "_ack"},   32'(wr_ack),     0);
    chk({tag, "_sd"},    32'(swap_done),  0);
    chk({tag, "_fb"},    32'(front_bank), 0);
    chk({tag, "_pix"},   32'(pix_out),    0);
    chk({tag, "_pv"},    32'(pix_valid),  0);
    chk({tag, "_addr"},  32'(mem_addr),   0);
    chk({tag, "_wdata"}, 32'(mem_wdata),  0);
  endtask

  // One pixel clock: predict, clock, serve the RAM, compare, advance stimulus
  task automatic tick();
    bit hit, slot, grant, apply, arm_here;
    int faddr, word, o_addr, o_wdata;
    bit o_re, o_we;
    o_re = mem_re; o_we = mem_we; o_addr = int'(mem_addr); o_wdata = int'(mem_wdata);
    if (!RESET_N) begin
      e_re = 0; e_we = 0; e_ack = 0; e_sd = 0; e_pix = 0; e_pv = 0; e_fb = 0;
      fb_m = 0; pend_m = 0; prev_grant = 0; armed_m = 0; pix_chk = 0;
    end else begin
      fetch_rule(bx, by, hit, faddr);
      arm_here = (bx == H_TOTAL - PPW) && (by == V_TOTAL - 1);
      slot     = hit && (armed_m || arm_here);
      grant    = wr_req && !slot && !prev_grant;
      e_re     = slot ? 1 : 0;
      e_raddr  = (fb_m << FA_BITS) | faddr;
      e_we     = grant ? 1 : 0;
      e_ack    = e_we;
      e_waddr  = ((1 - fb_m) << FA_BITS) | w_addr;
      e_wdata  = int'(wr_data);
      e_pv     = in_image ? 1 : 0;
      e_pix    = 0;
      if (in_image && pix_chk) begin
        word  = int'(ram[AW'((fb_m << FA_BITS) | (by * G + bx / PPW))]);
        e_pix = (word >> (PIX_BITS * (bx % PPW))) & ((1 << PIX_BITS) - 1);
      end
      apply  = (by == V_ACTIVE) && (bx == 0) && (pend_m != 0);
      e_sd   = apply ? 1 : 0;
      if (apply) fb_m = 1 - fb_m;
      pend_m = apply ? int'(swap_req) : (pend_m | int'(swap_req));
      prev_grant = grant;
      if (arm_here) armed_m = 1'b1;
      p_chk = pix_chk;
      if (bx == H_TOTAL - 1 && by == V_TOTAL - 1) pix_chk = armed_m;
      e_fb = fb_m;
    end
    if (!RESET_N) p_chk = 1'b0;
    px = bx; py = by; prst = RESET_N;

    @(posedge PIXEL_CLK);
    #1;
    if (o_we) ram[AW'(o_addr)] = WORD_BITS'(o_wdata);
    if (o_re) mem_rdata = ram[AW'(o_addr)];

    chk("mem_re",     32'(mem_re),          e_re);
    chk("mem_we",     32'(mem_we),          e_we);
    chk("wr_ack",     32'(wr_ack),          e_ack);
    chk("re_we_excl", 32'(mem_re & mem_we), 0);
    chk("swap_done",  32'(swap_done),       e_sd);
    chk("front_bank", 32'(front_bank),      e_fb);
    chk("pix_valid",  32'(pix_valid),       e_pv);
    chk("pix_out",    32'(pix_out),         e_pix);
    if (e_re != 0) chk("rd_addr", 32'(mem_addr), e_raddr);
    if (e_we != 0) begin
      chk("wr_addr",  32'(mem_addr),  e_waddr);
      chk("wr_wdata", 32'(mem_wdata), e_wdata);
    end
    if (!prst) begin
      chk("rst_addr",  32'(mem_addr),  0);
      chk("rst_wdata", 32'(mem_wdata), 0);
    end
    if (dir_pix && p_chk && py == 0 && px < 2 * PPW) chk("row0_pix", 32'(pix_out), px + 1);

    bx++;
    if (bx == H_TOTAL) begin
      bx = 0;
      by = (by == V_TOTAL - 1) ? 0 : by + 1;
    end
    drive_raster();
    if (wr_req && wr_ack) begin
      if (wmode == 1 || (wmode == 0 && $urandom_range(1, 0) == 1)) new_req();
      else wr_req = 1'b0;
    end else if (!wr_req && (wmode == 1 || (wmode == 0 && $urandom_range(3, 0) == 0))) begin
      new_req();
    end
    swap_req = swap_rand && ($urandom_range(39, 0) == 0);
  endtask

  task automatic run_to(input int tx, input int ty);
    int n;
    n = 0;
    while (!(bx == tx && by == ty) && n < 4 * FRAME) begin
      tick();
      n++;
    end
    if (!(bx == tx && by == ty)) begin
      errors++;
      $error("FAIL run_to: observed (%0d,%0d) expected (%0d,%0d)", bx, by, tx, ty);
    end
  endtask

  initial begin
    int n;
    for (int unsigned i = 0; i < MEM_WORDS; i++) ram[i] = WORD_BITS'($urandom);
    ram[0] = 16'h4321;
    ram[1] = 16'h8765;
    RESET_N = 1'b1; bx = 10; by = 7; drive_raster();
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; w_addr = 0; swap_req = 1'b0;
    mem_rdata = '0; wmode = 2; swap_rand = 1'b0; dir_pix = 1'b0;
    fb_m = 0; pend_m = 0; prev_grant = 1'b0; armed_m = 1'b0; pix_chk = 1'b0;

    // Reset applies without a clock edge, then holds through several clocks
    #2 RESET_N = 1'b0;
    #1 check_zero("async_rst");
    run_to(0, 0);

    // Release at (0,0): first read must come from the row-0 prefetch slot
    RESET_N = 1'b1;
    wmode   = 1;
    n = 0;
    while (mem_re !== 1'b1 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    if (mem_re !== 1'b1) begin
      errors++;
      $error("FAIL first_mem_re: observed none expected a read within %0d cycles", n);
    end else begin
      chk("first_re_x", px, H_TOTAL - PPW);
      chk("first_re_y", py, V_TOTAL - 1);
    end

    // Row 0 shows pixels 1..8 from words 0 and 1; writer keeps hammering
    dir_pix = 1'b1;
    run_to(0, 1);
    dir_pix = 1'b0;
    run_to(0, V_ACTIVE);
    wmode = 0;

    // Swap requests (repeated pulse) mid-frame, applied at start of vblank
    run_to(5, 3);
    swap_req = 1'b1; tick();
    run_to(7, 3);
    swap_req = 1'b1; tick();
    run_to(0, V_ACTIVE);
    swap_req = 1'b1; tick();
    chk("t4_swap_done", 32'(swap_done), 1);
    chk("t4_front",     32'(front_bank), 1);
    tick();
    run_to(0, V_ACTIVE);
    tick();
    chk("t4_held_done",  32'(swap_done), 1);
    chk("t4_held_front", 32'(front_bank), 0);
    tick();
    chk("t4_done_pulse", 32'(swap_done), 0);
    swap_rand = 1'b1;

    // Write request raised exactly on a video slot
    wmode = 2;
    n = 0;
    while (wr_req && n < 100) begin tick(); n++; end
    tick();
    run_to(4, 1);
    new_req();
    tick();
    chk("t5_re",        32'(mem_re), 1);
    chk("t5_ack_early", 32'(wr_ack), 0);
    tick();
    chk("t5_ack",       32'(wr_ack), 1);
    chk("t5_we",        32'(mem_we), 1);
    wmode = 0;

    // Reset pulse mid-frame, then clean scan-out from the next frame on
    run_to(H_ACTIVE / 2, V_ACTIVE / 2);
    RESET_N = 1'b0;
    #1 check_zero("mid_rst");
    for (int i = 0; i < 3; i++) tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
